// File: rtl/ascon_pack.sv
// Shared types and helpers for the ASCON permutation path.
package ascon_pack;

    // Five 64-bit lanes; index 0 is x0 (leftmost word in a concatenation).
    typedef logic [0:4][63:0] type_state;

    localparam int NB_ROUNDS_MAX = 12;

    // Permutation control states, exported so checkers can observe them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Round constant c_i = {(F - i), i}; XORed into the low byte of x2.
    function automatic logic [7:0] round_constant(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

endpackage

// File: rtl/constant_addition.sv
// Constant-addition layer: XOR the round constant into the low byte of x2.
module constant_addition
    import ascon_pack::*;
(
    input  type_state  i_state,
    input  logic [3:0] i_round,
    output type_state  o_state
);

    // Only x2[7:0] changes; the other lanes pass straight through.
    always_comb begin
        o_state          = i_state;
        o_state[2][7:0]  = i_state[2][7:0] ^ round_constant(i_round);
    end

endmodule

// File: rtl/diffusion_layer.sv
// Linear diffusion layer: each lane XORed with two rotations of itself.
module diffusion_layer
    import ascon_pack::*;
(
    input  type_state i_state,
    output type_state o_state
);

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    assign o_state[0] = i_state[0] ^ ror64(i_state[0], 19) ^ ror64(i_state[0], 28);
    assign o_state[1] = i_state[1] ^ ror64(i_state[1], 61) ^ ror64(i_state[1], 39);
    assign o_state[2] = i_state[2] ^ ror64(i_state[2], 1)  ^ ror64(i_state[2], 6);
    assign o_state[3] = i_state[3] ^ ror64(i_state[3], 10) ^ ror64(i_state[3], 17);
    assign o_state[4] = i_state[4] ^ ror64(i_state[4], 7)  ^ ror64(i_state[4], 41);

endmodule

// File: rtl/permutation_fsm.sv
// Control for the iterative permutation: IDLE/RUN/DONE FSM plus round counter.
//
// Handshake: start is sampled only in IDLE; an accepted start moves to RUN
// for one cycle per round, then DONE for exactly one cycle (done pulse),
// then back to IDLE. Starts seen in RUN or DONE are dropped, never queued.
module permutation_fsm
    import ascon_pack::*;
#(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_mode,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_round,
    output logic       o_load_en,
    output fsm_state_t o_fsm_state
);

    localparam logic [3:0] LAST_ROUND  = 4'(NB_ROUNDS_A - 1);
    localparam logic [3:0] FIRST_B_IDX = 4'(NB_ROUNDS_A - NB_ROUNDS_B);

    fsm_state_t r_fsm_state;
    logic [3:0] r_round;

    // FSM and round counter; the counter saturates at the last round index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm_state <= ST_IDLE;
            r_round     <= 4'd0;
        end else begin
            case (r_fsm_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_fsm_state <= ST_RUN;
                        r_round     <= i_mode ? FIRST_B_IDX : 4'd0;
                    end
                end
                ST_RUN: begin
                    if (r_round == LAST_ROUND) begin
                        r_fsm_state <= ST_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_fsm_state <= ST_IDLE;
                end
                default: begin
                    r_fsm_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status is decoded purely from the state register.
    assign o_busy      = (r_fsm_state == ST_RUN);
    assign o_done      = (r_fsm_state == ST_DONE);
    assign o_round     = r_round;
    assign o_fsm_state = r_fsm_state;
    assign o_load_en   = (r_fsm_state == ST_IDLE) && i_start;

endmodule

// File: rtl/substitution_layer.sv
// Substitution layer: the ASCON 5-bit S-box applied bit-sliced over 64 columns.
module substitution_layer
    import ascon_pack::*;
(
    input  type_state i_state,
    output type_state o_state
);

    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;

    // Input linear mix.
    assign w_a0 = i_state[0] ^ i_state[4];
    assign w_a1 = i_state[1];
    assign w_a2 = i_state[2] ^ i_state[1];
    assign w_a3 = i_state[3];
    assign w_a4 = i_state[4] ^ i_state[3];

    // Chi-like nonlinear step: x_i ^= ~x_(i+1) & x_(i+2).
    assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
    assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
    assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
    assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
    assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

    // Output linear mix; x1 and x3 use the pre-update x0 and x2.
    assign o_state[0] = w_b0 ^ w_b4;
    assign o_state[1] = w_b1 ^ w_b0;
    assign o_state[2] = ~w_b2;
    assign o_state[3] = w_b3 ^ w_b2;
    assign o_state[4] = w_b4;

endmodule

// File: rtl/permutation_engine.sv
// Iterative ASCON permutation, one round per clock, p^a (12) or p^b (6).
// The state register here is the only storage in the permutation path.
module permutation_engine
    import ascon_pack::*;
#(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] round_o
);

    type_state  r_state;
    type_state  w_ca_state;
    type_state  w_sb_state;
    type_state  w_df_state;
    logic [3:0] w_round;
    logic       w_load_en;
    logic       w_update_en;
    fsm_state_t w_fsm_state;

    permutation_fsm #(
        .NB_ROUNDS_A (NB_ROUNDS_A),
        .NB_ROUNDS_B (NB_ROUNDS_B)
    ) u_fsm (
        .i_clk       (clock_i),
        .i_rst_n     (resetb_i),
        .i_start     (start_i),
        .i_mode      (mode_i),
        .o_busy      (busy_o),
        .o_done      (done_o),
        .o_round     (w_round),
        .o_load_en   (w_load_en),
        .o_fsm_state (w_fsm_state)
    );

    // One full round: constant addition -> S-box -> diffusion.
    constant_addition u_ca (
        .i_state (r_state),
        .i_round (w_round),
        .o_state (w_ca_state)
    );

    substitution_layer u_sb (
        .i_state (w_ca_state),
        .o_state (w_sb_state)
    );

    diffusion_layer u_df (
        .i_state (w_sb_state),
        .o_state (w_df_state)
    );

    assign w_update_en = (w_fsm_state == ST_RUN);

    // State register: load on accepted start, advance one round per RUN cycle.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= '0;
        end else if (w_load_en) begin
            r_state <= state_i;
        end else if (w_update_en) begin
            r_state <= w_df_state;
        end
    end

    assign state_o = r_state;
    assign round_o = w_round;

endmodule

// File: tb/tb_permutation_engine.sv
// Self-checking bench for permutation_engine with a reference ASCON model.
module tb_permutation_engine;
    import ascon_pack::*;

    // ---------------- clock / reset ----------------
    logic       clock_i;
    logic       resetb_i;
    logic       start_i;
    logic       mode_i;
    type_state  state_i;
    type_state  state_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] round_o;

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    permutation_engine #(
        .NB_ROUNDS_A (12),
        .NB_ROUNDS_B (6)
    ) u_dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .round_o  (round_o)
    );

    // ---------------- reference model ----------------
    localparam logic [7:0] RC_TAB [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };
    localparam logic [4:0] SBOX_TAB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] ref_ror(input logic [63:0] x, input int n);
        logic [63:0] r;
        for (int b = 0; b < 64; b++) r[b] = x[(b + n) % 64];
        return r;
    endfunction

    function automatic type_state ref_const(input type_state s, input int i);
        type_state r;
        r = s;
        r[2][7:0] = s[2][7:0] ^ RC_TAB[i];
        return r;
    endfunction

    function automatic type_state ref_sbox(input type_state s);
        type_state  r;
        logic [4:0] idx;
        logic [4:0] o;
        for (int b = 0; b < 64; b++) begin
            idx = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o = SBOX_TAB[idx];
            r[0][b] = o[4];
            r[1][b] = o[3];
            r[2][b] = o[2];
            r[3][b] = o[1];
            r[4][b] = o[0];
        end
        return r;
    endfunction

    function automatic type_state ref_linear(input type_state s);
        type_state r;
        r[0] = s[0] ^ ref_ror(s[0], 19) ^ ref_ror(s[0], 28);
        r[1] = s[1] ^ ref_ror(s[1], 61) ^ ref_ror(s[1], 39);
        r[2] = s[2] ^ ref_ror(s[2], 1)  ^ ref_ror(s[2], 6);
        r[3] = s[3] ^ ref_ror(s[3], 10) ^ ref_ror(s[3], 17);
        r[4] = s[4] ^ ref_ror(s[4], 7)  ^ ref_ror(s[4], 41);
        return r;
    endfunction

    function automatic type_state golden(input type_state s, input logic m);
        type_state r;
        r = s;
        for (int i = (m ? 6 : 0); i < 12; i++) r = ref_linear(ref_sbox(ref_const(r, i)));
        return r;
    endfunction

    function automatic type_state rand_state();
        type_state r;
        for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
        return r;
    endfunction

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [319:0] exp_q[$];
    logic [319:0] last_exp;
    int           done_cnt = 0;

    always @(negedge clock_i) begin
        if (resetb_i && done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("done_without_request", 320'(exp_q.size()), 320'(1));
            end else begin
                check("result", state_o, exp_q.pop_front());
            end
        end
    end

    // Round-constant monitor on the constant-addition layer.
    logic       rc_mon = 1'b0;
    logic [7:0] rc0    = 8'h00;
    logic [7:0] rc11   = 8'h00;

    always @(negedge clock_i) begin
        if (rc_mon && busy_o) begin
            if (round_o == 4'd0)  rc0  = u_dut.w_ca_state[2][7:0] ^ u_dut.r_state[2][7:0];
            if (round_o == 4'd11) rc11 = u_dut.w_ca_state[2][7:0] ^ u_dut.r_state[2][7:0];
        end
    end

    // ---------------- driver ----------------
    // Call at a negedge while the DUT is IDLE; returns at a negedge in IDLE.
    task automatic run_perm(input logic m, input type_state s,
                            input logic poke_run, input logic poke_done);
        int n;
        int first;
        n     = m ? 6 : 12;
        first = m ? 6 : 0;
        start_i = 1'b1;
        mode_i  = m;
        state_i = s;
        last_exp = golden(s, m);
        exp_q.push_back(last_exp);
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        mode_i  = ~m;
        state_i = rand_state();
        for (int c = 0; c < n; c++) begin
            @(negedge clock_i);
            check("busy_run", 320'(busy_o), 320'(1));
            check("round_step", 320'(round_o), 320'(first + c));
            check("done_run", 320'(done_o), 320'(0));
            if (poke_run && c == 2) begin
                start_i = 1'b1;
                state_i = rand_state();
            end else begin
                start_i = 1'b0;
            end
        end
        @(negedge clock_i);
        check("done_pulse", 320'(done_o), 320'(1));
        check("busy_done", 320'(busy_o), 320'(0));
        check("round_hold", 320'(round_o), 320'(11));
        if (poke_done) begin
            start_i = 1'b1;
            state_i = rand_state();
        end
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        @(negedge clock_i);
        check("done_after", 320'(done_o), 320'(0));
        check("busy_after", 320'(busy_o), 320'(0));
        check("state_stable", state_o, last_exp);
    endtask

    // ---------------- main sequence ----------------
    localparam type_state PA_IN = {64'h80400c0600000000, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f};
    localparam type_state PB_IN = {64'h78e2cc41faabaa1a, 64'hbc7a2e775aababf7,
                                   64'h4b81c0cbbdb5fc1a, 64'hb22e133e424f0250,
                                   64'h044d33702433805d};

    initial begin
        int d0;
        resetb_i = 1'b0;
        start_i  = 1'b0;
        mode_i   = 1'b0;
        state_i  = '0;
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        resetb_i = 1'b1;
        @(negedge clock_i);
        check("rst_state", state_o, 320'(0));
        check("rst_round", 320'(round_o), 320'(0));
        check("rst_busy", 320'(busy_o), 320'(0));
        check("rst_done", 320'(done_o), 320'(0));

        // p^a and p^b with the reference vectors.
        run_perm(1'b0, PA_IN, 1'b0, 1'b0);
        run_perm(1'b1, PB_IN, 1'b0, 1'b0);

        // Starts during RUN and DONE are dropped; exactly one done pulse.
        d0 = done_cnt;
        run_perm(1'b0, rand_state(), 1'b1, 1'b1);
        @(negedge clock_i);
        check("ignored_start_busy", 320'(busy_o), 320'(0));
        check("one_done_pulse", 320'(done_cnt - d0), 320'(1));

        // Back-to-back: second start in the first IDLE cycle after DONE.
        run_perm(1'b1, rand_state(), 1'b0, 1'b0);
        run_perm(1'b0, rand_state(), 1'b0, 1'b0);
        run_perm(1'b1, rand_state(), 1'b1, 1'b0);

        // Round constants seen at the constant-addition layer.
        rc_mon = 1'b1;
        run_perm(1'b0, '0, 1'b0, 1'b0);
        rc_mon = 1'b0;
        check("rc_round0", 320'(rc0), 320'(8'hf0));
        check("rc_round11", 320'(rc11), 320'(8'h4b));

        // Asynchronous reset in the middle of a run.
        d0 = done_cnt;
        start_i = 1'b1;
        mode_i  = 1'b0;
        state_i = PA_IN;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        repeat (3) @(negedge clock_i);
        #2;
        resetb_i = 1'b0;
        #1;
        check("async_rst_state", state_o, 320'(0));
        check("async_rst_busy", 320'(busy_o), 320'(0));
        check("async_rst_done", 320'(done_o), 320'(0));
        check("async_rst_round", 320'(round_o), 320'(0));
        @(negedge clock_i);
        resetb_i = 1'b1;
        repeat (15) @(negedge clock_i);
        check("aborted_no_done", 320'(done_cnt - d0), 320'(0));
        check("aborted_idle", 320'(busy_o), 320'(0));
        check("queue_empty", 320'(exp_q.size()), 320'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
